// File: rtl/spi_xfer_seq_if.sv
// Bundles the processor-side FIFO ports and the SPI-block buffer/status ports of spi_xfer_seq.
// slave is the sequencer's view; master is the view of whoever drives it.
interface spi_xfer_seq_if;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       busy;
  logic       to_err;
  logic       err_clr;
  logic       spi_wr;
  logic [7:0] spi_dout;
  logic       spi_rd;
  logic [7:0] spi_din;
  logic       spi_stat_rd;
  logic       spi_bf;

  modport slave (
    input  tx_wr, tx_data, rx_rd, err_clr, spi_din, spi_bf,
    output tx_full, rx_data, rx_empty, busy, to_err,
           spi_wr, spi_dout, spi_rd, spi_stat_rd
  );

  modport master (
    output tx_wr, tx_data, rx_rd, err_clr, spi_din, spi_bf,
    input  tx_full, rx_data, rx_empty, busy, to_err,
           spi_wr, spi_dout, spi_rd, spi_stat_rd
  );
endinterface

// File: rtl/spi_xfer_seq.sv
// Byte-transfer sequencer in front of the SPI master: TX FIFO -> SPI buffer write,
// wait on the SPI busy flag, SPI buffer read -> RX FIFO.
module spi_xfer_seq #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int START_TO = 15
) (
  input logic           clk,
  input logic           reset,
  spi_xfer_seq_if.slave bus
);

  localparam int TW = $clog2(START_TO + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST    = TW'(START_TO - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    W_START,
    W_DONE,
    READ,
    CAPT
  } state_t;

  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    tx_mem_d [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d;
  logic [AW-1:0] tx_rp_q, tx_rp_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    rx_mem_d [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_wp_d;
  logic [AW-1:0] rx_rp_q, rx_rp_d;
  logic [AW:0]   rx_cnt_q, rx_cnt_d;

  state_t        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_err_q, to_err_d;
  logic          spi_wr_q, spi_wr_d;
  logic [7:0]    spi_dout_q, spi_dout_d;
  logic          spi_rd_q, spi_rd_d;
  logic          stat_rd_q, stat_rd_d;

  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_empty, rx_full;

  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign tx_push  = bus.tx_wr && (tx_cnt_q != FULL_CNT);
  assign tx_pop   = (state_q == LOAD);
  assign rx_push  = (state_q == CAPT);
  assign rx_pop   = bus.rx_rd && (rx_cnt_q != '0);

  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wp_q] = bus.tx_data;
      tx_wp_d           = tx_wp_q + 1'b1;
    end
    if (tx_pop) begin
      tx_rp_d = tx_rp_q + 1'b1;
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_comb begin
    rx_mem_d = rx_mem_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wp_q] = bus.spi_din;
      rx_wp_d           = rx_wp_q + 1'b1;
    end
    if (rx_pop) begin
      rx_rp_d = rx_rp_q + 1'b1;
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // The RX room check in IDLE is what guarantees CAPT always has a free slot.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
    if (bus.err_clr) begin
      to_err_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (!tx_empty && !rx_full) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        to_cnt_d = '0;
        state_d  = W_START;
      end
      W_START: begin
        if (bus.spi_bf) begin
          state_d = W_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_LAST) begin
            to_err_d = 1'b1;
            state_d  = READ;
          end
        end
      end
      W_DONE: begin
        if (!bus.spi_bf) begin
          state_d = READ;
        end
      end
      READ:    state_d = CAPT;
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_comb begin
    spi_wr_d   = (state_d == LOAD);
    spi_dout_d = (state_d == LOAD) ? tx_mem_q[tx_rp_q] : 8'h00;
    spi_rd_d   = (state_d == READ);
    stat_rd_d  = (state_d == W_START) || (state_d == W_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      state_q    <= IDLE;
      to_cnt_q   <= '0;
      to_err_q   <= 1'b0;
      spi_wr_q   <= 1'b0;
      spi_dout_q <= '0;
      spi_rd_q   <= 1'b0;
      stat_rd_q  <= 1'b0;
    end else begin
      tx_mem_q   <= tx_mem_d;
      rx_mem_q   <= rx_mem_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      to_err_q   <= to_err_d;
      spi_wr_q   <= spi_wr_d;
      spi_dout_q <= spi_dout_d;
      spi_rd_q   <= spi_rd_d;
      stat_rd_q  <= stat_rd_d;
    end
  end

  assign bus.tx_full     = (tx_cnt_q == FULL_CNT);
  assign bus.rx_empty    = (rx_cnt_q == '0);
  assign bus.rx_data     = (rx_cnt_q == '0) ? 8'h00 : rx_mem_q[rx_rp_q];
  assign bus.busy        = (state_q != IDLE);
  assign bus.to_err      = to_err_q;
  assign bus.spi_wr      = spi_wr_q;
  assign bus.spi_dout    = spi_dout_q;
  assign bus.spi_rd      = spi_rd_q;
  assign bus.spi_stat_rd = stat_rd_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: an SPI-block model echoes each written byte XOR 0x99,
// and queues hold the bytes expected on spi_dout and on rx_data.
module tb_spi_xfer_seq;
  localparam int DEPTH    = 4;
  localparam int START_TO = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  spi_xfer_seq_if bus ();

  spi_xfer_seq #(.DEPTH(DEPTH), .AW(2), .START_TO(START_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int cnt_wr   = 0;
  int cnt_rd   = 0;
  bit never_bf = 1'b0;
  int bf_delay = 2;
  int bf_hold  = 16;
  int m_phase  = 0;
  int m_cnt    = 0;

  // SPI block model: busy rises bf_delay cycles after a buffer write and stays up bf_hold cycles.
  initial begin
    logic [7:0] e;
    bus.spi_bf  = 1'b0;
    bus.spi_din = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_phase    = 0;
        bus.spi_bf = 1'b0;
      end else begin
        if (bus.spi_bf) begin
          total++;
          if (bus.spi_stat_rd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stat_rd_during_bf: got %b want 1", bus.spi_stat_rd);
          end
        end
        if (m_phase == 1) begin
          m_cnt--;
          if (m_cnt == 0) begin
            bus.spi_bf = 1'b1;
            m_phase    = 2;
            m_cnt      = bf_hold;
          end
        end else if (m_phase == 2) begin
          m_cnt--;
          if (m_cnt == 0) begin
            bus.spi_bf = 1'b0;
            m_phase    = 0;
          end
        end
        if (bus.spi_wr === 1'b1) begin
          cnt_wr++;
          total++;
          if (exp_tx.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_spi_wr: got dout %h want no write", bus.spi_dout);
          end else begin
            e = exp_tx.pop_front();
            if (bus.spi_dout !== e) begin
              bad++;
              $display("[TB] FAIL tx_byte: got %h want %h", bus.spi_dout, e);
            end
          end
          bus.spi_din = bus.spi_dout ^ 8'h99;
          exp_rx.push_back(bus.spi_dout ^ 8'h99);
          if (!never_bf) begin
            m_phase = 1;
            m_cnt   = bf_delay;
          end
        end
        if (bus.spi_rd === 1'b1) begin
          cnt_rd++;
          total++;
          if (bus.spi_bf !== 1'b0 || m_phase != 0) begin
            bad++;
            $display("[TB] FAIL rd_while_busy: got bf %b want 0", bus.spi_bf);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    bus.tx_wr   = 1'b1;
    bus.tx_data = b;
    if (accept) exp_tx.push_back(b);
    @(negedge clk);
    bus.tx_wr = 1'b0;
  endtask

  task automatic pop_rx();
    logic [7:0] e;
    total++;
    if (bus.rx_empty !== 1'b0 || exp_rx.size() == 0) begin
      bad++;
      $display("[TB] FAIL rx_pop: got rx_empty %b, %0d expected want data", bus.rx_empty, exp_rx.size());
    end else begin
      e = exp_rx.pop_front();
      if (bus.rx_data !== e) begin
        bad++;
        $display("[TB] FAIL rx_byte: got %h want %h", bus.rx_data, e);
      end
    end
    bus.rx_rd = 1'b1;
    @(negedge clk);
    bus.rx_rd = 1'b0;
  endtask

  task automatic drain_rx(input int n, input int budget);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (bus.rx_empty === 1'b0) begin
        pop_rx();
        got++;
      end else begin
        @(negedge clk);
      end
    end
    total++;
    if (got != n) begin
      bad++;
      $display("[TB] FAIL drain_rx: got %0d bytes want %0d", got, n);
    end
  endtask

  task automatic wait_idle(input int rd_target, input int budget);
    int c = 0;
    while (c < budget && !(cnt_rd >= rd_target && bus.busy === 1'b0)) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c >= budget) begin
      bad++;
      $display("[TB] FAIL wait_idle: got rd %0d busy %b want rd %0d busy 0", cnt_rd, bus.busy, rd_target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.busy, bus.tx_full, bus.rx_empty, bus.to_err, bus.spi_wr, bus.spi_rd, bus.spi_stat_rd} !== 7'b0010000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b want 0010000",
               {bus.busy, bus.tx_full, bus.rx_empty, bus.to_err, bus.spi_wr, bus.spi_rd, bus.spi_stat_rd});
    end
    total++;
    if (bus.spi_dout !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_dout: got %h want 00", bus.spi_dout);
    end
    total++;
    if (bus.rx_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_rx_data: got %h want 00", bus.rx_data);
    end
  endtask

  task automatic test_single();
    int w0 = cnt_wr;
    int r0 = cnt_rd;
    push(8'hA5, 1'b1);
    wait_idle(r0 + 1, 200);
    total++;
    if (cnt_wr - w0 != 1 || cnt_rd - r0 != 1) begin
      bad++;
      $display("[TB] FAIL single_strobes: got wr %0d rd %0d want 1 1", cnt_wr - w0, cnt_rd - r0);
    end
    total++;
    if (bus.rx_empty !== 1'b0 || bus.rx_data !== 8'h3C) begin
      bad++;
      $display("[TB] FAIL single_rx: got empty %b data %h want 0 3c", bus.rx_empty, bus.rx_data);
    end
    total++;
    if (bus.to_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_to_err: got %b want 0", bus.to_err);
    end
    pop_rx();
  endtask

  task automatic test_fill();
    int w0 = cnt_wr;
    int r0 = cnt_rd;
    int c  = 0;
    push(8'h10, 1'b1);
    while (c < 20 && bus.spi_wr !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    push(8'h04, 1'b1);
    total++;
    if (bus.tx_full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fill_full: got %b want 1", bus.tx_full);
    end
    push(8'h05, 1'b0);
    total++;
    if (bus.tx_full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fill_drop_full: got %b want 1", bus.tx_full);
    end
    drain_rx(5, 600);
    wait_idle(r0 + 5, 100);
    total++;
    if (cnt_wr - w0 != 5 || exp_tx.size() != 0) begin
      bad++;
      $display("[TB] FAIL fill_count: got wr %0d pending %0d want 5 0", cnt_wr - w0, exp_tx.size());
    end
  endtask

  task automatic test_rx_stall();
    int w0 = cnt_wr;
    int r0 = cnt_rd;
    int n;
    bit found;
    bf_hold = 4;
    for (int i = 0; i < 5; i++) push(8'h31 + 8'(i), 1'b1);
    wait_idle(r0 + 4, 300);
    repeat (20) @(negedge clk);
    total++;
    if (cnt_wr - w0 != 4 || bus.busy !== 1'b0 || bus.rx_empty !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_hold: got wr %0d busy %b want wr 4 busy 0", cnt_wr - w0, bus.busy);
    end
    pop_rx();
    n = 1;
    found = (bus.spi_wr === 1'b1);
    if (!found) begin
      @(negedge clk);
      n = 2;
      found = (bus.spi_wr === 1'b1);
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL stall_release: got no spi_wr in %0d cycles want within 2", n);
    end
    drain_rx(4, 300);
    wait_idle(r0 + 5, 100);
    bf_hold = 16;
  endtask

  task automatic test_timeout();
    int r0 = cnt_rd;
    int c  = 0;
    int n  = 0;
    never_bf = 1'b1;
    push(8'h77, 1'b1);
    while (c < 20 && bus.spi_wr !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    while (n < 40 && bus.to_err !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != START_TO + 1) begin
      bad++;
      $display("[TB] FAIL timeout_latency: got %0d cycles after LOAD want %0d", n, START_TO + 1);
    end
    wait_idle(r0 + 1, 50);
    drain_rx(1, 20);
    total++;
    if (bus.to_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_sticky: got %b want 1", bus.to_err);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    total++;
    if (bus.to_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_clear: got %b want 0", bus.to_err);
    end
    never_bf = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c = 0;
    int w1;
    int r1;
    push(8'h51, 1'b1);
    push(8'h52, 1'b1);
    push(8'h53, 1'b1);
    while (c < 30 && bus.spi_bf !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.tx_full, bus.rx_empty, bus.spi_wr, bus.spi_rd} !== 5'b00100) begin
      bad++;
      $display("[TB] FAIL reset_mid_flags: got %b want 00100",
               {bus.busy, bus.tx_full, bus.rx_empty, bus.spi_wr, bus.spi_rd});
    end
    @(negedge clk);
    reset = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    w1 = cnt_wr;
    r1 = cnt_rd;
    repeat (40) @(negedge clk);
    total++;
    if (cnt_wr != w1 || cnt_rd != r1 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_quiet: got wr +%0d rd +%0d busy %b want 0 0 0", cnt_wr - w1, cnt_rd - r1, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = cnt_wr;
    int r0 = cnt_rd;
    push(8'h61, 1'b1);
    @(negedge clk);
    total++;
    if (bus.spi_wr !== 1'b1) begin
      bad++;
      $display("[TB] FAIL simul_load_align: got spi_wr %b want 1", bus.spi_wr);
    end
    push(8'h62, 1'b1);
    push(8'h63, 1'b1);
    push(8'h64, 1'b1);
    total++;
    if (bus.tx_full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL simul_not_full: got %b want 0", bus.tx_full);
    end
    push(8'h65, 1'b1);
    total++;
    if (bus.tx_full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL simul_full: got %b want 1", bus.tx_full);
    end
    drain_rx(5, 600);
    wait_idle(r0 + 5, 100);
    total++;
    if (cnt_wr - w0 != 5 || exp_tx.size() != 0) begin
      bad++;
      $display("[TB] FAIL simul_count: got wr %0d pending %0d want 5 0", cnt_wr - w0, exp_tx.size());
    end
  endtask

  initial begin
    bus.tx_wr   = 1'b0;
    bus.tx_data = 8'h00;
    bus.rx_rd   = 1'b0;
    bus.err_clr = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_rx_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_xfer_seq.md
Name: spi_xfer_seq

Overview:
Byte-transfer sequencer placed directly upstream of the SPI master top block. It accepts bytes from the processor side into a TX FIFO and drives the SPI block's buffer-write strobe for each byte. It watches the SPI busy flag, reads each received byte back through the buffer-read strobe into an RX FIFO, and serves that RX FIFO to the processor. This removes per-byte polling of the SPI status register from the IL processor.

Parameters:
DEPTH, 4, entries in each of the TX and RX FIFOs (power of two, at least 2)
AW, 2, pointer width, equal to log2(DEPTH)
START_TO, 15, cycles to wait for the busy flag to rise after a buffer write before timing out

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
tx_wr  input  1  push tx_data into the TX FIFO
tx_data  input  8  byte to transmit
tx_full  output  1  TX FIFO full
rx_rd  input  1  pop the RX FIFO head
rx_data  output  8  RX FIFO head byte, valid while rx_empty=0
rx_empty  output  1  RX FIFO empty
busy  output  1  high whenever the FSM is not in IDLE
to_err  output  1  sticky start-timeout flag
err_clr  input  1  clear to_err
spi_wr  output  1  buffer-write strobe to the SPI block
spi_dout  output  8  byte to the SPI block's buffer input
spi_rd  output  1  buffer-read strobe to the SPI block
spi_din  input  8  SPI block's buffer output
spi_stat_rd  output  1  status-read enable to the SPI block
spi_bf  input  1  SPI busy/transfer flag, taken from the SPI status output

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: all outputs 0 except tx_full=0 and rx_empty=1. FIFO pointers and counts clear, FSM goes to IDLE, timeout counter clears, to_err clears.
- Reset mid-transfer: abandons the byte in flight; no further SPI strobes follow.
- FIFOs: circular buffers of DEPTH x 8 with AW-bit pointers that wrap modulo DEPTH. Count width is AW+1.
- tx_wr when full is ignored and nothing is overwritten.
- rx_rd when empty is ignored.
- rx_data is the registered head, i.e. first-word fall-through.
- Simultaneous tx_wr with an FSM pop, or rx_rd with an FSM push, is legal; the count is unchanged.
- spi_stat_rd is high in W_START and W_DONE, low otherwise.
- FSM states:
  - IDLE: if the TX FIFO is not empty and the RX FIFO is not full, go to LOAD.
  - LOAD (1 cycle): spi_wr=1, spi_dout = TX head; pop TX; clear the timeout counter; go to W_START.
  - W_START: if spi_bf=1, go to W_DONE. Otherwise increment the counter; when the counter reaches START_TO, set to_err and go to READ, because a missed or very short transfer is treated as complete.
  - W_DONE: wait for spi_bf=0, then go to READ. There is no timeout in this state.
  - READ (1 cycle): spi_rd=1; go to CAPT.
  - CAPT (1 cycle): push spi_din into the RX FIFO; go to IDLE.
- The RX-not-full check happens before LOAD, so CAPT never overflows the RX FIFO.
- Minimum per-byte latency: LOAD to CAPT is 4 cycles plus the SPI busy duration.
- One cycle is spent in IDLE between bytes, so back-to-back bytes are separated by at least 1 idle cycle.
- to_err: set and err_clr in the same cycle means set wins; err_clr alone clears it.
- busy is combinationally (state != IDLE).
- The byte popped in LOAD is never re-sent.

Test Plan:
- Reset, then push 0xA5; SPI model raises spi_bf 2 cycles after spi_wr, holds it 16 cycles, returns 0x3C. Required: spi_wr pulses once with spi_dout=0xA5; spi_rd pulses once after spi_bf falls; rx_data=0x3C with rx_empty=0; to_err=0.
- Push 0x01, 0x02, 0x03, 0x04 (DEPTH=4) in consecutive cycles. Required: tx_full=1 after the 4th push; a 5th push of 0x05 is dropped; the spi_dout sequence is 01, 02, 03, 04; the RX order matches the SPI return order.
- RX-full stall: complete 4 transfers without any rx_rd, with a 5th byte queued. Required: no spi_wr for the 5th byte until a single rx_rd, then spi_wr follows within 2 cycles.
- Timeout: the SPI model never raises spi_bf. Required: to_err=1 exactly START_TO cycles after entering W_START; spi_rd still pulses; a byte is captured. Pulse err_clr and check that to_err returns to 0.
- Reset in W_DONE with 2 bytes queued. Required: busy=0, tx_full=0, rx_empty=1 next cycle; no spi_wr or spi_rd after reset until new tx_wr.
- Simultaneous tx_wr and the LOAD pop when 1 entry is present. Required: the TX count stays 1 and both bytes are eventually sent in order.
